readresp_serializer: RTL and testbench

//  Parametrised successor of the tag read-reply serializer. On start, emits one Gen2 Read reply bitstream:

---
 rtl/rfid_pkg.sv | 24 ++
 rtl/readresp_serializer_if.sv | 28 ++
 rtl/crc16_serial.sv | 20 ++
 rtl/readresp_serializer.sv | 155 +++++++++++++++
 tb/tb_readresp_serializer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rfid_pkg.sv
// Shared Gen2 reply definitions: CRC-16 constants, the serial CRC step and
// the read-reply state encoding.
package rfid_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_HANDLE = 3'd3,
    ST_CRC    = 3'd4,
    ST_DONE   = 3'd5
  } reply_state_e;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/readresp_serializer_if.sv
// Command-side and FIFO-side signals of the read-reply serializer.
interface readresp_serializer_if #(
  parameter int DATA_W   = 8,
  parameter int HANDLE_W = 16
);
  logic                start;
  logic                abort;
  logic                bit_en;
  logic [7:0]          readwords;
  logic [HANDLE_W-1:0] handle;
  logic [DATA_W-1:0]   fifo_datain;
  logic                fifo_start;
  logic                fifo_nextout;
  logic                readbitout;
  logic                readbitvalid;
  logic                readbitdone;
  logic                busy;

  modport master (
    output start, abort, bit_en, readwords, handle, fifo_datain,
    input  fifo_start, fifo_nextout, readbitout, readbitvalid, readbitdone, busy
  );

  modport slave (
    input  start, abort, bit_en, readwords, handle, fifo_datain,
    output fifo_start, fifo_nextout, readbitout, readbitvalid, readbitdone, busy
  );
endinterface

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 (poly 0x1021); synchronous clear to the preset wins over enable.
module crc16_serial
  import rfid_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  always_ff @(posedge clk) begin
    if (clr) begin
      crc_out <= CRC16_PRESET;
    end else if (en) begin
      crc_out <= crc16_step(crc_out, bit_in);
    end
  end

endmodule

// File: rtl/readresp_serializer.sv
// Gen2 Read reply serializer: header, N FIFO bytes, handle and optional
// complemented CRC-16, one bit per bit_en strobe.
module readresp_serializer
  import rfid_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int HANDLE_W    = 16,
  parameter int DEFAULT_WDS = 5,
  parameter int CRC_EN      = 1
) (
  input  logic                  readbitclk,
  input  logic                  reset_n,
  readresp_serializer_if.slave  bus
);

  localparam int IDX_MAX = (DATA_W > HANDLE_W) ? ((DATA_W > 16) ? DATA_W : 16)
                                               : ((HANDLE_W > 16) ? HANDLE_W : 16);
  localparam int IDX_W   = $clog2(IDX_MAX);
  localparam int DIDX_W  = $clog2(DATA_W);
  localparam int HIDX_W  = $clog2(HANDLE_W);

  localparam logic [IDX_W-1:0] DATA_TOP   = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] HANDLE_TOP = IDX_W'(HANDLE_W - 1);
  localparam logic [IDX_W-1:0] CRC_TOP    = IDX_W'(15);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [8:0]       DEF_BYTES  = 9'(2 * DEFAULT_WDS);

  reply_state_e        state_q, state_d;
  logic [8:0]          bytes_left_q, bytes_left_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HANDLE_W-1:0] handle_q;
  logic                fifo_start_q, fifo_start_d;
  logic                fifo_nextout_q, fifo_nextout_d;
  logic                start_acc;
  logic                crc_clr, crc_upd;
  logic                bit_out;
  logic [15:0]         crc_q;

  // abort outranks start; start only lands when no reply is in flight
  assign start_acc = bus.start && !bus.abort &&
                     (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d        = state_q;
    bytes_left_d   = bytes_left_q;
    idx_d          = idx_q;
    fifo_start_d   = 1'b0;
    fifo_nextout_d = 1'b0;
    if (bus.abort) begin
      state_d      = ST_IDLE;
      bytes_left_d = '0;
      idx_d        = '0;
    end else if (start_acc) begin
      state_d      = ST_HEADER;
      fifo_start_d = 1'b1;
      bytes_left_d = (bus.readwords == 8'd0) ? DEF_BYTES : {bus.readwords, 1'b0};
      idx_d        = '0;
    end else if (bus.bit_en) begin
      case (state_q)
        ST_HEADER: begin
          state_d = ST_DATA;
          idx_d   = DATA_TOP;
        end
        ST_DATA: begin
          if (idx_q == '0) begin
            fifo_nextout_d = 1'b1;
            bytes_left_d   = bytes_left_q - 9'd1;
            if (bytes_left_q == 9'd1) begin
              state_d = ST_HANDLE;
              idx_d   = HANDLE_TOP;
            end else begin
              idx_d = DATA_TOP;
            end
          end else begin
            idx_d = idx_q - IDX_ONE;
          end
        end
        ST_HANDLE: begin
          if (idx_q == '0) begin
            if (CRC_EN != 0) begin
              state_d = ST_CRC;
              idx_d   = CRC_TOP;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            idx_d = idx_q - IDX_ONE;
          end
        end
        ST_CRC: begin
          if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q - IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge readbitclk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      bytes_left_q   <= '0;
      idx_q          <= '0;
      fifo_start_q   <= 1'b0;
      fifo_nextout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bytes_left_q   <= bytes_left_d;
      idx_q          <= idx_d;
      fifo_start_q   <= fifo_start_d;
      fifo_nextout_q <= fifo_nextout_d;
    end
  end

  always_ff @(posedge readbitclk) begin
    if (start_acc) begin
      handle_q <= bus.handle;
    end
  end

  always_comb begin
    bit_out = 1'b0;
    case (state_q)
      ST_DATA:   bit_out = bus.fifo_datain[idx_q[DIDX_W-1:0]];
      ST_HANDLE: bit_out = handle_q[idx_q[HIDX_W-1:0]];
      ST_CRC:    bit_out = ~crc_q[idx_q[3:0]];
      default:   bit_out = 1'b0;
    endcase
  end

  // CRC covers header, data and handle; it is frozen once its own bits go out
  assign crc_clr = !reset_n || start_acc;
  assign crc_upd = bus.bit_en && !bus.abort &&
                   (state_q == ST_HEADER || state_q == ST_DATA || state_q == ST_HANDLE);

  crc16_serial u_crc (
    .clk     (readbitclk),
    .clr     (crc_clr),
    .en      (crc_upd),
    .bit_in  (bit_out),
    .crc_out (crc_q)
  );

  assign bus.readbitout   = bit_out;
  assign bus.readbitvalid = (state_q == ST_HEADER) || (state_q == ST_DATA) ||
                            (state_q == ST_HANDLE) || (state_q == ST_CRC);
  assign bus.busy         = bus.readbitvalid;
  assign bus.readbitdone  = (state_q == ST_DONE);
  assign bus.fifo_start   = fifo_start_q;
  assign bus.fifo_nextout = fifo_nextout_q;

endmodule

// File: tb/tb_readresp_serializer.sv
// Randomized bench for readresp_serializer: two instances (without and with CRC)
// share one stimulus and are compared against a bit-queue reply model.
module tb_readresp_serializer;
  import rfid_pkg::*;

  logic readbitclk = 1'b0;
  always #5 readbitclk = ~readbitclk;

  logic        reset_n;
  logic        drv_start, drv_abort, drv_bit_en;
  logic [7:0]  drv_readwords;
  logic [15:0] drv_handle;

  readresp_serializer_if #(.DATA_W(8), .HANDLE_W(16)) if0 ();
  readresp_serializer_if #(.DATA_W(8), .HANDLE_W(16)) if1 ();

  readresp_serializer #(.DATA_W(8), .HANDLE_W(16), .DEFAULT_WDS(5), .CRC_EN(0)) dut0 (
    .readbitclk (readbitclk), .reset_n (reset_n), .bus (if0.slave));
  readresp_serializer #(.DATA_W(8), .HANDLE_W(16), .DEFAULT_WDS(5), .CRC_EN(1)) dut1 (
    .readbitclk (readbitclk), .reset_n (reset_n), .bus (if1.slave));

  assign if0.start = drv_start;   assign if1.start = drv_start;
  assign if0.abort = drv_abort;   assign if1.abort = drv_abort;
  assign if0.bit_en = drv_bit_en; assign if1.bit_en = drv_bit_en;
  assign if0.readwords = drv_readwords; assign if1.readwords = drv_readwords;
  assign if0.handle = drv_handle; assign if1.handle = drv_handle;

  // FIFO model: fifo_start rewinds to byte 0, fifo_nextout steps; next byte shown while the pulse is high
  logic [7:0] mem [0:1023];
  int ptr0 = 0, ptr1 = 0;
  always @(posedge readbitclk) begin
    if (if0.fifo_start) ptr0 <= 0; else if (if0.fifo_nextout) ptr0 <= ptr0 + 1;
    if (if1.fifo_start) ptr1 <= 0; else if (if1.fifo_nextout) ptr1 <= ptr1 + 1;
  end
  assign if0.fifo_datain = mem[10'(if0.fifo_start ? 0 : ptr0 + int'(if0.fifo_nextout))];
  assign if1.fifo_datain = mem[10'(if1.fifo_start ? 0 : ptr1 + int'(if1.fifo_nextout))];

  bit cap0[$], cap1[$];
  int nxt0_tot = 0, nxt1_tot = 0, fs0_tot = 0, fs1_tot = 0;
  always @(negedge readbitclk) begin
    if (drv_bit_en && !drv_abort && if0.readbitvalid) cap0.push_back(if0.readbitout);
    if (drv_bit_en && !drv_abort && if1.readbitvalid) cap1.push_back(if1.readbitout);
    if (if0.fifo_nextout) nxt0_tot <= nxt0_tot + 1;
    if (if1.fifo_nextout) nxt1_tot <= nxt1_tot + 1;
    if (if0.fifo_start)   fs0_tot  <= fs0_tot + 1;
    if (if1.fifo_start)   fs1_tot  <= fs1_tot + 1;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] crc_over(input bit q[$]);
    logic [15:0] c;
    logic        fb;
    c = CRC16_PRESET;
    foreach (q[i]) begin
      fb = c[15] ^ q[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    return c;
  endfunction

  bit          exp0[$], exp1[$];
  logic [15:0] exp_crc_field;
  task automatic build_exp(input int nbytes, input logic [15:0] h);
    logic [15:0] c;
    exp0.delete();
    exp0.push_back(1'b0);
    for (int b = 0; b < nbytes; b++)
      for (int i = 7; i >= 0; i--) exp0.push_back(mem[b][i]);
    for (int i = 15; i >= 0; i--) exp0.push_back(h[i]);
    exp1 = exp0;
    c = crc_over(exp0);
    exp_crc_field = ~c;
    for (int i = 15; i >= 0; i--) exp1.push_back(~c[i]);
  endtask

  task automatic cmp_stream(input string tag, input bit got[$], input bit exp[$], input int n);
    int nerr = 0;
    chk({tag, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size() && i < exp.size(); i++)
      if (got[i] != exp[i]) nerr++;
    chk({tag, "_bits"}, nerr, 0);
  endtask

  task automatic fill_mem(input int nbytes);
    for (int b = 0; b < nbytes; b++) mem[b] = 8'($urandom);
  endtask

  int nxt0_base, nxt1_base, fs0_base, fs1_base;
  task automatic run_reply(input logic [7:0] rw, input logic [15:0] h, input int gapmax,
                           input int abort_k, input int restart_k, output bit timed_out);
    int k, gap;
    cap0.delete(); cap1.delete();
    nxt0_base = nxt0_tot; nxt1_base = nxt1_tot; fs0_base = fs0_tot; fs1_base = fs1_tot;
    timed_out = 1'b0;
    @(posedge readbitclk); #1;
    drv_readwords = rw; drv_handle = h; drv_start = 1'b1;
    @(posedge readbitclk); #1;
    drv_start = 1'b0; drv_readwords = 8'($urandom); drv_handle = 16'($urandom);
    k = 0;
    while (1) begin
      if (k >= 1500) begin timed_out = 1'b1; break; end
      gap = (gapmax == 0) ? 0 : $urandom_range(gapmax, 0);
      repeat (gap) begin @(posedge readbitclk); #1; end
      k++;
      drv_bit_en = 1'b1;
      drv_abort  = (k == abort_k);
      drv_start  = (k == restart_k);
      @(posedge readbitclk); #1;
      drv_bit_en = 1'b0; drv_abort = 1'b0; drv_start = 1'b0;
      if (k == abort_k) break;
      if (if0.readbitdone && if1.readbitdone) break;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy0"}, if0.busy, 0);         chk({tag, "_busy1"}, if1.busy, 0);
    chk({tag, "_valid0"}, if0.readbitvalid, 0); chk({tag, "_valid1"}, if1.readbitvalid, 0);
    chk({tag, "_out0"}, if0.readbitout, 0);    chk({tag, "_out1"}, if1.readbitout, 0);
    chk({tag, "_done0"}, if0.readbitdone, 0);  chk({tag, "_done1"}, if1.readbitdone, 0);
    chk({tag, "_nxt0"}, if0.fifo_nextout, 0);  chk({tag, "_fs1"}, if1.fifo_start, 0);
  endtask

  task automatic chk_full(input string tag, input int nbytes);
    logic [15:0] fld;
    cmp_stream({tag, "_s0"}, cap0, exp0, 1 + 8 * nbytes + 16);
    cmp_stream({tag, "_s1"}, cap1, exp1, 1 + 8 * nbytes + 32);
    chk({tag, "_nxt0"}, nxt0_tot - nxt0_base, nbytes);
    chk({tag, "_nxt1"}, nxt1_tot - nxt1_base, nbytes);
    chk({tag, "_fs0"}, fs0_tot - fs0_base, 1);
    chk({tag, "_fs1"}, fs1_tot - fs1_base, 1);
    chk({tag, "_done0"}, if0.readbitdone, 1);
    chk({tag, "_done1"}, if1.readbitdone, 1);
    chk({tag, "_valid1"}, if1.readbitvalid, 0);
    chk({tag, "_resid"}, crc_over(cap1), CRC16_RESIDUE);
    fld = '0;
    for (int i = cap1.size() - 16; i < cap1.size(); i++)
      if (i >= 0) fld = {fld[14:0], cap1[i]};
    chk({tag, "_crcfld"}, fld, exp_crc_field);
  endtask

  initial begin
    bit          to;
    logic [63:0] v;
    logic [7:0]  rw;
    logic [15:0] h;
    reset_n = 1'b0; drv_start = 1'b0; drv_abort = 1'b0; drv_bit_en = 1'b0;
    drv_readwords = '0; drv_handle = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) @(posedge readbitclk);
    #1;
    chk_quiet("rst");
    reset_n = 1'b1;

    // fixed reply without gaps
    mem[0] = 8'hA5; mem[1] = 8'h3C;
    run_reply(8'd1, 16'hBEEF, 0, 0, 0, to);
    chk("t1_tmo", to, 0);
    build_exp(2, 16'hBEEF);
    chk_full("t1", 2);
    v = '0;
    foreach (cap0[i]) v = {v[62:0], cap0[i]};
    chk("t1_word", v, 64'h00000000A53CBEEF);

    // default length
    fill_mem(10);
    h = 16'($urandom);
    run_reply(8'd0, h, 1, 0, 0, to);
    chk("t2_tmo", to, 0);
    build_exp(10, h);
    chk_full("t2", 10);

    // random data, random bit_en gaps
    for (int it = 0; it < 4; it++) begin
      rw = 8'($urandom_range(4, 1));
      fill_mem(2 * int'(rw));
      h = 16'($urandom);
      run_reply(rw, h, 7, 0, 0, to);
      chk("t3_tmo", to, 0);
      build_exp(2 * int'(rw), h);
      chk_full("t3", 2 * int'(rw));
    end

    // abort after 11 bits, then abort on a byte-completing bit, then replay
    fill_mem(6);
    h = 16'($urandom);
    build_exp(6, h);
    run_reply(8'd3, h, 2, 12, 0, to);
    chk_quiet("t5a");
    cmp_stream("t5a_s1", cap1, exp1, 11);
    repeat (4) @(posedge readbitclk);
    #1;
    chk("t5a_nxt0", nxt0_tot - nxt0_base, 1);
    chk("t5a_nxt1", nxt1_tot - nxt1_base, 1);
    run_reply(8'd3, h, 0, 17, 0, to);
    repeat (4) @(posedge readbitclk);
    #1;
    chk("t5b_nxt0", nxt0_tot - nxt0_base, 1);
    chk("t5b_busy1", if1.busy, 0);
    run_reply(8'd3, h, 3, 0, 0, to);
    chk("t5c_tmo", to, 0);
    chk_full("t5c", 6);

    // start and abort together from DONE: abort wins
    drv_start = 1'b1; drv_abort = 1'b1;
    @(posedge readbitclk); #1;
    drv_start = 1'b0; drv_abort = 1'b0;
    chk_quiet("t5d");

    // reset mid-handle
    fill_mem(2);
    h = 16'($urandom);
    run_reply(8'd1, h, 0, 22, 0, to);
    reset_n = 1'b0;
    @(posedge readbitclk); #1;
    reset_n = 1'b1;
    chk_quiet("t6a");
    nxt0_base = nxt0_tot;
    repeat (5) begin
      drv_bit_en = 1'b1;
      @(posedge readbitclk); #1;
      drv_bit_en = 1'b0;
    end
    chk_quiet("t6b");
    chk("t6b_nxt0", nxt0_tot - nxt0_base, 0);

    // start while busy is ignored
    fill_mem(4);
    h = 16'($urandom);
    run_reply(8'd2, h, 1, 0, 5, to);
    chk("t6c_tmo", to, 0);
    build_exp(4, h);
    chk_full("t6c", 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
